// File: rtl/accum_window_capture.sv
// rtl/accum_window_capture.sv - windowed capture of accumulator sum and sticky flags with valid/ready output
// Optional: define ACCUM_WINDOW_SATURATE_EN to saturate captured data on carry/overflow.
module accum_window_capture #(
    parameter int N      = 8,
    parameter int WINDOW = 16,
    parameter int CW     = 16
) (
    input  logic          clk,
    input  logic          aclr,
    input  logic          en,
    input  logic [N-1:0]  S,
    input  logic          overflow,
    input  logic          carry,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic          out_ovf,
    output logic          out_carry,
    output logic [CW-1:0] win_cnt,
    output logic [7:0]    drop_cnt
);
    typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_t;

    localparam logic [CW-1:0] LAST = CW'(WINDOW - 1);

    state_t        state_q, state_d;
    logic [CW-1:0] win_cnt_q, win_cnt_d;
    logic          sticky_ovf_q, sticky_ovf_d;
    logic          sticky_carry_q, sticky_carry_d;
    logic [N-1:0]  out_data_q, out_data_d;
    logic          out_ovf_q, out_ovf_d;
    logic          out_carry_q, out_carry_d;
    logic [7:0]    drop_cnt_q, drop_cnt_d;

    logic          wend;
    logic          load;
    logic          drop;
    logic          cap_ovf;
    logic          cap_carry;
    logic [N-1:0]  cap_data;

    // The window-end sample's own flags belong to the window being captured.
    assign wend      = en && (win_cnt_q == LAST);
    assign cap_ovf   = sticky_ovf_q | overflow;
    assign cap_carry = sticky_carry_q | carry;

`ifdef ACCUM_WINDOW_SATURATE_EN
    always_comb begin
        cap_data = S;
        if (cap_carry) begin
            cap_data = '1;
        end else if (cap_ovf) begin
            cap_data = S[N-1] ? {1'b1, {(N-1){1'b0}}} : {1'b0, {(N-1){1'b1}}};
        end
    end
`else
    assign cap_data = S;
`endif

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            state_q <= EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY:   if (wend) state_d = FULL;
            FULL:    if (out_ready && !wend) state_d = EMPTY;
            default: state_d = EMPTY;
        endcase
    end

    // A ready consumer frees the register in the same cycle a new result lands.
    always_comb begin
        out_valid = (state_q == FULL);
        load      = wend && ((state_q == EMPTY) || out_ready);
        drop      = wend && (state_q == FULL) && !out_ready;
    end

    always_comb begin
        win_cnt_d      = win_cnt_q;
        sticky_ovf_d   = sticky_ovf_q;
        sticky_carry_d = sticky_carry_q;
        out_data_d     = out_data_q;
        out_ovf_d      = out_ovf_q;
        out_carry_d    = out_carry_q;
        drop_cnt_d     = drop_cnt_q;
        if (en) begin
            if (wend) begin
                win_cnt_d      = '0;
                sticky_ovf_d   = 1'b0;
                sticky_carry_d = 1'b0;
            end else begin
                win_cnt_d      = win_cnt_q + CW'(1);
                sticky_ovf_d   = cap_ovf;
                sticky_carry_d = cap_carry;
            end
        end
        if (load) begin
            out_data_d  = cap_data;
            out_ovf_d   = cap_ovf;
            out_carry_d = cap_carry;
        end
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge aclr) begin
        if (!aclr) begin
            win_cnt_q      <= '0;
            sticky_ovf_q   <= 1'b0;
            sticky_carry_q <= 1'b0;
            out_data_q     <= '0;
            out_ovf_q      <= 1'b0;
            out_carry_q    <= 1'b0;
            drop_cnt_q     <= '0;
        end else begin
            win_cnt_q      <= win_cnt_d;
            sticky_ovf_q   <= sticky_ovf_d;
            sticky_carry_q <= sticky_carry_d;
            out_data_q     <= out_data_d;
            out_ovf_q      <= out_ovf_d;
            out_carry_q    <= out_carry_d;
            drop_cnt_q     <= drop_cnt_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_ovf   = out_ovf_q;
    assign out_carry = out_carry_q;
    assign win_cnt   = win_cnt_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_accum_window_capture.sv
// tb/tb_accum_window_capture.sv - self-checking bench for accum_window_capture
module tb_accum_window_capture;
    localparam int N      = 8;
    localparam int WINDOW = 4;
    localparam int CW     = 16;

    logic          clk = 1'b0;
    logic          aclr;
    logic          en;
    logic [N-1:0]  S;
    logic          overflow;
    logic          carry;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  out_data;
    logic          out_ovf;
    logic          out_carry;
    logic [CW-1:0] win_cnt;
    logic [7:0]    drop_cnt;

    accum_window_capture #(.N(N), .WINDOW(WINDOW), .CW(CW)) dut (
        .clk       (clk),
        .aclr      (aclr),
        .en        (en),
        .S         (S),
        .overflow  (overflow),
        .carry     (carry),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_ovf   (out_ovf),
        .out_carry (out_carry),
        .win_cnt   (win_cnt),
        .drop_cnt  (drop_cnt)
    );

    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;

    // Reference: samples of the open window, plus the capture register contents.
    int m_s[$];
    bit m_o[$];
    bit m_c[$];
    bit m_valid;
    int m_data;
    bit m_ovf;
    bit m_carry;
    int m_drop;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int s, input bit o, input bit c);
`ifdef ACCUM_WINDOW_SATURATE_EN
        if (c) return (1 << N) - 1;
        if (o) return (s >= (1 << (N - 1))) ? (1 << (N - 1)) : (1 << (N - 1)) - 1;
        return s;
`else
        return s;
`endif
    endfunction

    task automatic model_reset();
        m_s.delete();
        m_o.delete();
        m_c.delete();
        m_valid = 1'b0;
        m_data  = 0;
        m_ovf   = 1'b0;
        m_carry = 1'b0;
        m_drop  = 0;
    endtask

    task automatic check_all();
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("out_data",  32'(out_data),  32'(m_data));
        chk("out_ovf",   32'(out_ovf),   32'(m_ovf));
        chk("out_carry", 32'(out_carry), 32'(m_carry));
        chk("win_cnt",   32'(win_cnt),   32'(m_s.size()));
        chk("drop_cnt",  32'(drop_cnt),  32'(m_drop));
    endtask

    task automatic step(input bit e, input int s, input bit o, input bit c, input bit r);
        bit w;
        bit any_o;
        bit any_c;
        int rs;
        w = 1'b0; any_o = 1'b0; any_c = 1'b0; rs = 0;
        en = e; S = s[N-1:0]; overflow = o; carry = c; out_ready = r;
        if (e) begin
            m_s.push_back(s & ((1 << N) - 1));
            m_o.push_back(o);
            m_c.push_back(c);
            if (m_s.size() == WINDOW) begin
                w = 1'b1;
                rs = m_s[WINDOW-1];
                foreach (m_o[i]) any_o |= m_o[i];
                foreach (m_c[i]) any_c |= m_c[i];
                m_s.delete(); m_o.delete(); m_c.delete();
            end
        end
        if (m_valid && r) m_valid = 1'b0;
        if (w) begin
            if (!m_valid) begin
                m_valid = 1'b1;
                m_data  = sat(rs, any_o, any_c);
                m_ovf   = any_o;
                m_carry = any_c;
            end else if (m_drop < 255) begin
                m_drop++;
            end
        end
        @(posedge clk);
        #1;
        check_all();
    endtask

    initial begin
        int exp_sat1;
        int exp_sat2;
`ifdef ACCUM_WINDOW_SATURATE_EN
        exp_sat1 = 8'hFF;
        exp_sat2 = 8'h80;
`else
        exp_sat1 = 8'h05;
        exp_sat2 = 8'h85;
`endif
        aclr = 1'b0; en = 1'b0; S = '0; overflow = 1'b0; carry = 1'b0; out_ready = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_all();
        aclr = 1'b1;

        // First window, consumer stalled.
        step(1, 10, 0, 0, 0);
        step(1, 20, 0, 0, 0);
        step(1, 30, 0, 0, 0);
        chk("pre_valid", 32'(out_valid), 32'd0);
        step(1, 40, 0, 0, 0);
        chk("win1_valid", 32'(out_valid), 32'd1);
        chk("win1_data", 32'(out_data), 32'd40);
        chk("win1_cnt", 32'(win_cnt), 32'd0);

        // Sticky carry mid-window, overflow on the window-end sample.
        step(1, 1, 0, 0, 1);
        step(1, 2, 0, 1, 1);
        step(1, 3, 0, 0, 1);
        step(1, 4, 0, 0, 1);
        chk("stk1_carry", 32'(out_carry), 32'd1);
        chk("stk1_ovf", 32'(out_ovf), 32'd0);
        step(1, 5, 0, 0, 1);
        step(1, 6, 0, 0, 1);
        step(1, 7, 0, 0, 1);
        step(1, 8, 1, 0, 1);
        chk("stk2_carry", 32'(out_carry), 32'd0);
        chk("stk2_ovf", 32'(out_ovf), 32'd1);

        // Back-pressure across three windows.
        step(0, 0, 0, 0, 1);
        for (int w = 0; w < 3; w++) begin
            for (int k = 0; k < WINDOW; k++) step(1, 8'h11 + 16 * w + (WINDOW - 1 - k), 0, 0, 0);
        end
        chk("bp_data", 32'(out_data), 32'h11);
        chk("bp_drop", 32'(drop_cnt), 32'd2);
        chk("bp_valid", 32'(out_valid), 32'd1);

        // Consumer ready on the window-end cycle itself.
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 8'h22, 0, 0, 1);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_data", 32'(out_data), 32'h22);
        chk("sim_drop", 32'(drop_cnt), 32'd2);

        // Enable gaps, then asynchronous reset while FULL mid-window.
        step(1, 9, 0, 0, 0);
        step(0, 9, 0, 0, 0);
        step(1, 9, 0, 0, 0);
        step(0, 9, 0, 0, 0);
        chk("gap_cnt", 32'(win_cnt), 32'd2);
        aclr = 1'b0;
        #2;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_cnt", 32'(win_cnt), 32'd0);
        chk("arst_drop", 32'(drop_cnt), 32'd0);
        model_reset();
        check_all();
        @(posedge clk);
        #1;
        aclr = 1'b1;

        // Capture-time saturation (or plain pass-through without the macro).
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 8'h05, 0, 1, 0);
        chk("sat_carry", 32'(out_data), 32'(exp_sat1));
        step(0, 0, 0, 0, 1);
        step(1, 1, 0, 0, 0);
        step(1, 2, 0, 0, 0);
        step(1, 3, 0, 0, 0);
        step(1, 8'h85, 1, 0, 0);
        chk("sat_ovf", 32'(out_data), 32'(exp_sat2));

        for (int i = 0; i < 600; i++) begin
            step($urandom_range(0, 3) != 0, int'($urandom_range(0, 255)),
                 $urandom_range(0, 7) == 0, $urandom_range(0, 7) == 0,
                 $urandom_range(0, 1) == 1);
        end

        // Drop counter saturation under sustained back-pressure.
        for (int i = 0; i < 260 * WINDOW; i++) begin
            step(1, int'($urandom_range(0, 255)), 0, 0, 0);
        end
        chk("drop_sat", 32'(drop_cnt), 32'd255);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
